// File: rtl/psum_accum_pkg.sv
// Shared constants and FSM encoding for the partial-sum accumulator.
package psum_accum_pkg;

    localparam int LANES  = 10;
    localparam int PSUM_W = 22;
    localparam int OUT_W  = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

endpackage

// File: rtl/psum_accum_if.sv
// Row stream in, quantised row stream out, plus sticky status flags.
interface psum_accum_if;
    import psum_accum_pkg::*;

    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*PSUM_W-1:0]   psum_in;
    logic                      first_ch;
    logic                      last_ch;
    logic                      out_valid;
    logic                      out_ready;
    logic [LANES*OUT_W-1:0]    ofmap_out;
    logic                      ovf_flag;
    logic                      proto_err;

    modport slave (
        input  in_valid, psum_in, first_ch, last_ch, out_ready,
        output in_ready, out_valid, ofmap_out, ovf_flag, proto_err
    );

    modport master (
        output in_valid, psum_in, first_ch, last_ch, out_ready,
        input  in_ready, out_valid, ofmap_out, ovf_flag, proto_err
    );

endinterface

// File: rtl/psum_fifo.sv
// Output row FIFO; DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module psum_fifo #(
    parameter int W     = 80,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         not_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign not_empty = (count_r != {CW{1'b0}});
    assign push_ok_s = push && !full;
    assign pop_ok_s  = pop && not_empty;
    // Empty FIFO presents zero so the output reads clean after reset.
    assign head_data = not_empty ? mem_r[rd_ptr_r] : {W{1'b0}};

    // Row storage, written at the tail.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/psum_accum.sv
// Accumulates per-lane partial sums across input channels, then ReLU/shift/clamp
// quantises each completed row into an output FIFO.
module psum_accum
    import psum_accum_pkg::*;
#(
    parameter int ACC_W = 28,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    psum_accum_if.slave   bus
);

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_e                  state_r;
    logic signed [ACC_W-1:0] acc_r      [LANES];
    logic                    ovf_r;
    logic                    proto_r;

    logic signed [ACC_W-1:0] lane_s     [LANES];
    logic        [ACC_W:0]   sum_s      [LANES];
    logic signed [ACC_W-1:0] sat_sum_s  [LANES];
    logic signed [ACC_W-1:0] nxt_acc_s  [LANES];
    logic [LANES-1:0]        sat_s;
    logic [LANES*OUT_W-1:0]  push_row_s;
    logic [LANES*OUT_W-1:0]  head_row_s;
    logic                    fifo_full_s;
    logic                    fifo_valid_s;
    logic                    accept_s;
    logic                    add_mode_s;
    logic                    load_s;
    logic                    push_s;
    logic                    ovf_set_s;

    function automatic logic [OUT_W-1:0] quant(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] sh;
        sh = v >>> SHIFT;
        if (v[ACC_W-1]) begin
            return {OUT_W{1'b0}};
        end else if (|sh[ACC_W-1:OUT_W]) begin
            return {OUT_W{1'b1}};
        end else begin
            return sh[OUT_W-1:0];
        end
    endfunction

    // Per-lane saturating add, restart/accumulate select and quantisation.
    always_comb begin
        accept_s   = bus.in_valid && !fifo_full_s;
        add_mode_s = (state_r == ST_ACCUM) && !bus.first_ch;
        load_s     = accept_s && (bus.first_ch || (state_r == ST_ACCUM));
        push_s     = load_s && bus.last_ch;
        sat_s      = {LANES{1'b0}};
        push_row_s = {(LANES*OUT_W){1'b0}};
        for (int k = 0; k < LANES; k++) begin
            lane_s[k] = {{(ACC_W-PSUM_W){bus.psum_in[k*PSUM_W+PSUM_W-1]}},
                         bus.psum_in[k*PSUM_W +: PSUM_W]};
            sum_s[k]  = {acc_r[k][ACC_W-1], acc_r[k]} + {lane_s[k][ACC_W-1], lane_s[k]};
            // Top two bits disagree only when the true sum left the ACC_W range.
            if (sum_s[k][ACC_W] != sum_s[k][ACC_W-1]) begin
                sat_s[k]     = 1'b1;
                sat_sum_s[k] = sum_s[k][ACC_W] ? ACC_MIN : ACC_MAX;
            end else begin
                sat_sum_s[k] = sum_s[k][ACC_W-1:0];
            end
            if (add_mode_s) begin
                nxt_acc_s[k] = sat_sum_s[k];
            end else begin
                nxt_acc_s[k] = lane_s[k];
            end
            push_row_s[k*OUT_W +: OUT_W] = quant(nxt_acc_s[k]);
        end
        ovf_set_s = accept_s && add_mode_s && (|sat_s);
    end

    // Channel sequencing FSM with accumulator and sticky flag state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            ovf_r   <= 1'b0;
            proto_r <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                acc_r[k] <= {ACC_W{1'b0}};
            end
        end else begin
            if (load_s) begin
                for (int k = 0; k < LANES; k++) begin
                    acc_r[k] <= nxt_acc_s[k];
                end
            end
            if (ovf_set_s) begin
                ovf_r <= 1'b1;
            end
            if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (bus.first_ch) begin
                            state_r <= bus.last_ch ? ST_IDLE : ST_ACCUM;
                        end else begin
                            proto_r <= 1'b1;
                        end
                    end
                    ST_ACCUM: begin
                        if (bus.first_ch) begin
                            proto_r <= 1'b1;
                            state_r <= bus.last_ch ? ST_IDLE : ST_ACCUM;
                        end else if (bus.last_ch) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end
        end
    end

    psum_fifo #(
        .W     (LANES*OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_row_s),
        .pop       (bus.out_ready),
        .head_data (head_row_s),
        .full      (fifo_full_s),
        .not_empty (fifo_valid_s)
    );

    assign bus.in_ready  = !fifo_full_s;
    assign bus.out_valid = fifo_valid_s;
    assign bus.ofmap_out = head_row_s;
    assign bus.ovf_flag  = ovf_r;
    assign bus.proto_err = proto_r;

endmodule
